// File: rtl/floppy_midi_pkg.sv
// floppy_midi_pkg
//   Shared constants for the floppy MIDI voice path:
//     SETP_W  - default step setpoint width (half-period in 50 MHz cycles)
//     NOTE_W  - MIDI note number width
//     CHAN_W  - MIDI channel width
//     BASE_W  - width of the octave-0 half-period table entries
//     state_t - allocator FSM encoding (IDLE/LOOKUP/SEARCH/UPDATE)
//     base_half_period() - 12-entry table, round(25e6 / f(k)) for MIDI notes 0..11
package floppy_midi_pkg;

  localparam int SETP_W = 22;
  localparam int NOTE_W = 7;
  localparam int CHAN_W = 4;
  localparam int BASE_W = 22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEARCH = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Half-periods of the lowest octave (C-1 .. B-1); higher octaves are
  // obtained by right-shifting. Callers never pass a semitone above 11.
  function automatic logic [BASE_W-1:0] base_half_period(input logic [3:0] semitone);
    case (semitone)
      4'd0:    return 22'd3057805;
      4'd1:    return 22'd2886184;
      4'd2:    return 22'd2724195;
      4'd3:    return 22'd2571297;
      4'd4:    return 22'd2426982;
      4'd5:    return 22'd2290766;
      4'd6:    return 22'd2162195;
      4'd7:    return 22'd2040840;
      4'd8:    return 22'd1926297;
      4'd9:    return 22'd1818182;
      4'd10:   return 22'd1716135;
      default: return 22'd1619816;
    endcase
  endfunction

endpackage

// File: rtl/note_period_rom.sv
// note_period_rom
//   One-cycle registered lookup from MIDI note number to step half-period.
//   setp = base_half_period(note mod 12) >> (note / 12), resized to OUT_W.
// Ports:
//   clk   in   system clock
//   note  in   MIDI note number (NOTE_W bits)
//   setp  out  registered half-period, valid the cycle after note is presented
module note_period_rom
  import floppy_midi_pkg::*;
#(
  parameter int OUT_W = SETP_W
) (
  input  logic              clk,
  input  logic [NOTE_W-1:0] note,
  output logic [OUT_W-1:0]  setp
);

  logic [3:0]        semitone;
  logic [3:0]        octave;
  logic [BASE_W-1:0] shifted;

  always_comb begin
    semitone = 4'(note % NOTE_W'(12));
    octave   = 4'(note / NOTE_W'(12));
    // Truncating shift: each octave up halves the period.
    shifted  = base_half_period(semitone) >> octave;
  end

  always_ff @(posedge clk) begin
    setp <= OUT_W'(shifted);
  end

endmodule

// File: rtl/floppy_voice_alloc.sv
// floppy_voice_alloc
//   Assigns MIDI note-on/off events to NUM_DRIVES floppy step generators.
//   Each event walks IDLE -> LOOKUP -> SEARCH -> UPDATE, so outputs change
//   three edges after acceptance and one event is taken every four cycles.
//   Optional build macro: FLOPPY_VOICE_STEAL_EN (round-robin voice stealing
//   when every drive is busy; otherwise such a note-on is dropped).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   note_valid/ready  event handshake (ready only while IDLE)
//   note_on, note_chan, note_num, note_vel  event fields (vel 0 = note-off)
//   panic             all-notes-off, aborts any in-flight event
//   drv_en            per-drive enable
//   drv_setp          packed setpoints, drive i at [i*SETP_W +: SETP_W]
//   drop_pulse        one-cycle pulse when an event is discarded
module floppy_voice_alloc
  import floppy_midi_pkg::state_t;
  import floppy_midi_pkg::IDLE;
  import floppy_midi_pkg::LOOKUP;
  import floppy_midi_pkg::SEARCH;
  import floppy_midi_pkg::UPDATE;
  import floppy_midi_pkg::NOTE_W;
  import floppy_midi_pkg::CHAN_W;
#(
  parameter int NUM_DRIVES = 2,
  parameter int SETP_W     = 22,
  parameter int MIN_NOTE   = 24,
  parameter int MAX_NOTE   = 83
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic                         note_on,
  input  logic [CHAN_W-1:0]            note_chan,
  input  logic [NOTE_W-1:0]            note_num,
  input  logic [6:0]                   note_vel,
  input  logic                         panic,
  output logic [NUM_DRIVES-1:0]        drv_en,
  output logic [NUM_DRIVES*SETP_W-1:0] drv_setp,
  output logic                         drop_pulse
);

  state_t                state_reg, state_next;
  logic                  ready_reg;
  logic                  accept;
  logic                  ev_on_reg;
  logic [CHAN_W-1:0]     ev_chan_reg;
  logic [NOTE_W-1:0]     ev_note_reg;
  logic                  in_range;
  logic [SETP_W-1:0]     rom_setp;
  logic [NUM_DRIVES-1:0] en_vec, match_comb, match_reg, free_reg;
  logic [NUM_DRIVES-1:0] load_vec, clr_vec;
  logic                  drop_next, drop_reg;

  logic                  en_reg         [NUM_DRIVES];
  logic [SETP_W-1:0]     setp_reg       [NUM_DRIVES];
  logic [CHAN_W-1:0]     owner_chan_reg [NUM_DRIVES];
  logic [NOTE_W-1:0]     owner_note_reg [NUM_DRIVES];

  assign note_ready = ready_reg;
  assign accept     = note_valid && ready_reg;
  assign drv_en     = en_vec;
  assign drop_pulse = drop_reg;
  assign in_range   = (int'(ev_note_reg) >= MIN_NOTE) && (int'(ev_note_reg) <= MAX_NOTE);

  genvar gi;
  for (gi = 0; gi < NUM_DRIVES; gi++) begin : g_drive
    assign en_vec[gi]     = en_reg[gi];
    assign match_comb[gi] = en_reg[gi] && (owner_chan_reg[gi] == ev_chan_reg)
                            && (owner_note_reg[gi] == ev_note_reg);
    assign drv_setp[gi*SETP_W +: SETP_W] = setp_reg[gi];
  end

  note_period_rom #(.OUT_W(SETP_W)) u_rom (
    .clk  (clk),
    .note (ev_note_reg),
    .setp (rom_setp)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Registered so ready stays low while reset is held.
      ready_reg <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LOOKUP;
      LOOKUP:  state_next = SEARCH;
      SEARCH:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (panic) state_next = IDLE;
  end

  // ---------------- event capture ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_on_reg   <= 1'b0;
      ev_chan_reg <= '0;
      ev_note_reg <= '0;
    end else if (accept) begin
      ev_on_reg   <= note_on && (note_vel != 7'd0);
      ev_chan_reg <= note_chan;
      ev_note_reg <= note_num;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_reg <= '0;
      free_reg  <= '0;
    end else if (state_reg == SEARCH) begin
      match_reg <= match_comb;
      free_reg  <= ~en_vec;
    end
  end

`ifdef FLOPPY_VOICE_STEAL_EN
  localparam int PTR_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  logic [PTR_W-1:0]      steal_ptr_reg;
  logic [NUM_DRIVES-1:0] steal_vec;
  logic                  steal_now;

  for (gi = 0; gi < NUM_DRIVES; gi++) begin : g_steal
    assign steal_vec[gi] = (steal_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      steal_ptr_reg <= '0;
    end else if (steal_now) begin
      steal_ptr_reg <= (steal_ptr_reg == PTR_W'(NUM_DRIVES - 1)) ? '0
                       : steal_ptr_reg + PTR_W'(1);
    end
  end
`endif

  // ---------------- update decision ----------------
  // x & -x isolates the lowest set bit, i.e. the lowest-index candidate.
  always_comb begin
    load_vec  = '0;
    clr_vec   = '0;
    drop_next = 1'b0;
`ifdef FLOPPY_VOICE_STEAL_EN
    steal_now = 1'b0;
`endif
    if (state_reg == UPDATE && !panic) begin
      if (!ev_on_reg) begin
        clr_vec = match_reg;
      end else if (!in_range) begin
        drop_next = 1'b1;
      end else if (|match_reg) begin
        load_vec = match_reg & (~match_reg + NUM_DRIVES'(1));
      end else if (|free_reg) begin
        load_vec = free_reg & (~free_reg + NUM_DRIVES'(1));
      end else begin
`ifdef FLOPPY_VOICE_STEAL_EN
        load_vec  = steal_vec;
        steal_now = 1'b1;
`else
        drop_next = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_reg <= 1'b0;
    else        drop_reg <= drop_next;
  end

  // Setpoints are left alone on release and panic so a drive resumes
  // from a known value; only enable and ownership are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (!rst_n) begin
        en_reg[i]         <= 1'b0;
        setp_reg[i]       <= '0;
        owner_chan_reg[i] <= '0;
        owner_note_reg[i] <= '0;
      end else if (panic || clr_vec[i]) begin
        en_reg[i]         <= 1'b0;
        owner_chan_reg[i] <= '0;
        owner_note_reg[i] <= '0;
      end else if (load_vec[i]) begin
        en_reg[i]         <= 1'b1;
        setp_reg[i]       <= rom_setp;
        owner_chan_reg[i] <= ev_chan_reg;
        owner_note_reg[i] <= ev_note_reg;
      end
    end
  end

endmodule
